surface_win_pos_gen: RTL and testbench

Window-position scan generator for the surface (feature-map) fetch path, sitting directly upstream of the logical-to-physical position converter. On one start it sweeps every convolution window over the padded (extended) feature map and every kernel tap within each window. For each tap it issues one logical (x, y) to the converter over its start/idle/done port, then forwards the returned physical position and validity flag as a valid/ready stream to the fetch-address stage.

---
 rtl/surface_pos_pkg.sv | 20 ++
 rtl/win_pos_cnt.sv | 88 ++++++++
 rtl/surface_win_pos_gen.sv | 135 +++++++++++++
 tb/tb_surface_win_pos_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/surface_pos_pkg.sv
// surface_pos_pkg: shared types, widths and span helper for the surface window position generator
package surface_pos_pkg;
  localparam int CW = 16;
  localparam int KW = 4;
  localparam int SW = 3;
  localparam int DW = 3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_e;
  function automatic logic [CW-1:0] span(input logic [KW-1:0] k, input logic [DW-1:0] d);
    logic [7:0] p;
    p = {4'd0, k} * ({5'd0, d} + 8'd1);
    return {{(CW-8){1'b0}}, p};
  endfunction
endpackage

// File: rtl/win_pos_cnt.sv
// win_pos_cnt: nested window/tap counter with incremental logical coordinates and last flags
module win_pos_cnt
  import surface_pos_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          adv,
  input  logic [CW-1:0] ext_j_right,
  input  logic [CW-1:0] ext_i_bottom,
  input  logic [CW-1:0] span_h,
  input  logic [CW-1:0] span_v,
  input  logic [KW-1:0] kernel_w,
  input  logic [KW-1:0] kernel_h,
  input  logic [SW-1:0] stride_h,
  input  logic [SW-1:0] stride_v,
  input  logic [DW-1:0] dilation_h,
  input  logic [DW-1:0] dilation_v,
  output logic [CW-1:0] logic_x,
  output logic [CW-1:0] logic_y,
  output logic          last_tap,
  output logic          last_win
);
  logic [CW-1:0] base_x_q, base_x_d, base_y_q, base_y_d;
  logic [CW-1:0] off_x_q, off_x_d, off_y_q, off_y_d;
  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0] dil_h, dil_v, nbx, nby;
  logic          last_kx, last_ky, row_wrap, col_end;
  // next-window bounds, tap position and counter advance
  always_comb begin
    dil_h    = {{(CW-DW){1'b0}}, dilation_h} + CW'(1);
    dil_v    = {{(CW-DW){1'b0}}, dilation_v} + CW'(1);
    nbx      = base_x_q + {{(CW-SW){1'b0}}, stride_h} + CW'(1);
    nby      = base_y_q + {{(CW-SW){1'b0}}, stride_v} + CW'(1);
    row_wrap = (nbx + span_h) > ext_j_right;
    col_end  = (nby + span_v) > ext_i_bottom;
    last_kx  = kx_q == kernel_w;
    last_ky  = ky_q == kernel_h;
    last_tap = last_kx && last_ky;
    last_win = last_tap && row_wrap && col_end;
    logic_x  = base_x_q + off_x_q;
    logic_y  = base_y_q + off_y_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    off_x_d  = off_x_q;
    off_y_d  = off_y_q;
    kx_d     = kx_q;
    ky_d     = ky_q;
    if (clr) begin
      base_x_d = '0;
      base_y_d = '0;
      off_x_d  = '0;
      off_y_d  = '0;
      kx_d     = '0;
      ky_d     = '0;
    end else if (adv) begin
      kx_d    = last_kx ? '0 : kx_q + KW'(1);
      off_x_d = last_kx ? '0 : off_x_q + dil_h;
      if (last_kx) begin
        ky_d    = last_ky ? '0 : ky_q + KW'(1);
        off_y_d = last_ky ? '0 : off_y_q + dil_v;
      end
      if (last_tap) begin
        base_x_d = row_wrap ? '0 : nbx;
        base_y_d = row_wrap ? nby : base_y_q;
      end
    end
  end
  // counter registers, frozen while the clock enable is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_x_q <= '0;
      base_y_q <= '0;
      off_x_q  <= '0;
      off_y_q  <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
    end else if (en) begin
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
      kx_q     <= kx_d;
      ky_q     <= ky_d;
    end
  end
endmodule

// File: rtl/surface_win_pos_gen.sv
// surface_win_pos_gen: sweeps windows and taps, issues logical positions to the converter, streams physical positions out
module surface_win_pos_gen
  import surface_pos_pkg::*;
#(
  parameter int SIM_DELAY = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        aclken,
  input  logic [15:0] ext_j_right,
  input  logic [15:0] ext_i_bottom,
  input  logic [3:0]  kernel_w,
  input  logic [3:0]  kernel_h,
  input  logic [2:0]  stride_h,
  input  logic [2:0]  stride_v,
  input  logic [2:0]  dilation_h,
  input  logic [2:0]  dilation_v,
  input  logic        blk_start,
  output logic        blk_idle,
  output logic        blk_done,
  output logic        cvt_start,
  input  logic        cvt_idle,
  output logic [15:0] cvt_i_logic_x,
  output logic [15:0] cvt_i_logic_y,
  input  logic        cvt_done,
  input  logic [15:0] cvt_o_phy_x,
  input  logic [15:0] cvt_o_phy_y,
  input  logic        cvt_o_is_vld,
  output logic        m_pos_valid,
  input  logic        m_pos_ready,
  output logic [15:0] m_pos_phy_x,
  output logic [15:0] m_pos_phy_y,
  output logic        m_pos_is_vld,
  output logic        m_pos_last_tap,
  output logic        m_pos_last_win
);
  state_e        state_q, state_d;
  logic [CW-1:0] span_h_q, span_h_d, span_v_q, span_v_d, span_h_w, span_v_w;
  logic [CW-1:0] phy_x_q, phy_x_d, phy_y_q, phy_y_d;
  logic          is_vld_q, is_vld_d, last_tap_q, last_tap_d, last_win_q, last_win_d;
  logic          cnt_clr, cnt_adv, cnt_last_tap, cnt_last_win;
  logic          sim_delay_unused;
  assign sim_delay_unused = SIM_DELAY != 0;
  win_pos_cnt u_cnt (
    .clk         (aclk),
    .rst_n       (aresetn),
    .en          (aclken),
    .clr         (cnt_clr),
    .adv         (cnt_adv),
    .ext_j_right (ext_j_right),
    .ext_i_bottom(ext_i_bottom),
    .span_h      (span_h_q),
    .span_v      (span_v_q),
    .kernel_w    (kernel_w),
    .kernel_h    (kernel_h),
    .stride_h    (stride_h),
    .stride_v    (stride_v),
    .dilation_h  (dilation_h),
    .dilation_v  (dilation_v),
    .logic_x     (cvt_i_logic_x),
    .logic_y     (cvt_i_logic_y),
    .last_tap    (cnt_last_tap),
    .last_win    (cnt_last_win)
  );
  assign blk_idle       = state_q == ST_IDLE;
  assign blk_done       = aclken && state_q == ST_DONE;
  assign cvt_start      = aclken && state_q == ST_ISSUE && cvt_idle;
  assign m_pos_valid    = state_q == ST_OUT;
  assign m_pos_phy_x    = phy_x_q;
  assign m_pos_phy_y    = phy_y_q;
  assign m_pos_is_vld   = is_vld_q;
  assign m_pos_last_tap = last_tap_q;
  assign m_pos_last_win = last_win_q;
  // scan sequencing: span setup, converter handshake, output beat and counter advance
  always_comb begin
    span_h_w   = span(kernel_w, dilation_h);
    span_v_w   = span(kernel_h, dilation_v);
    state_d    = state_q;
    span_h_d   = span_h_q;
    span_v_d   = span_v_q;
    phy_x_d    = phy_x_q;
    phy_y_d    = phy_y_q;
    is_vld_d   = is_vld_q;
    last_tap_d = last_tap_q;
    last_win_d = last_win_q;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = blk_start ? ST_INIT : ST_IDLE;
      ST_INIT: begin
        span_h_d = span_h_w;
        span_v_d = span_v_w;
        cnt_clr  = 1'b1;
        state_d  = (span_h_w > ext_j_right || span_v_w > ext_i_bottom) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: state_d = cvt_idle ? ST_WAIT : ST_ISSUE;
      ST_WAIT: if (cvt_done) begin
        phy_x_d    = cvt_o_phy_x;
        phy_y_d    = cvt_o_phy_y;
        is_vld_d   = cvt_o_is_vld;
        last_tap_d = cnt_last_tap;
        last_win_d = cnt_last_win;
        state_d    = ST_OUT;
      end
      ST_OUT: if (m_pos_ready) begin
        cnt_adv = 1'b1;
        state_d = last_win_q ? ST_DONE : ST_ISSUE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
  // state, span and output payload registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      span_h_q   <= '0;
      span_v_q   <= '0;
      phy_x_q    <= '0;
      phy_y_q    <= '0;
      is_vld_q   <= 1'b0;
      last_tap_q <= 1'b0;
      last_win_q <= 1'b0;
    end else if (aclken) begin
      state_q    <= state_d;
      span_h_q   <= span_h_d;
      span_v_q   <= span_v_d;
      phy_x_q    <= phy_x_d;
      phy_y_q    <= phy_y_d;
      is_vld_q   <= is_vld_d;
      last_tap_q <= last_tap_d;
      last_win_q <= last_win_d;
    end
  end
endmodule

// File: tb/tb_surface_win_pos_gen.sv
// tb_surface_win_pos_gen: table-driven scans against a nested-loop model plus reset and clock-enable sequences
module tb_surface_win_pos_gen;
  logic        aclk = 1'b0, aresetn = 1'b0, aclken = 1'b1;
  logic [15:0] ext_j_right = '0, ext_i_bottom = '0;
  logic [3:0]  kernel_w = '0, kernel_h = '0;
  logic [2:0]  stride_h = '0, stride_v = '0, dilation_h = '0, dilation_v = '0;
  logic        blk_start = 1'b0, blk_idle, blk_done, cvt_start, cvt_idle, cvt_done, cvt_o_is_vld;
  logic [15:0] cvt_i_logic_x, cvt_i_logic_y, cvt_o_phy_x, cvt_o_phy_y;
  logic        m_pos_valid, m_pos_ready = 1'b1, m_pos_is_vld, m_pos_last_tap, m_pos_last_win;
  logic [15:0] m_pos_phy_x, m_pos_phy_y;

  typedef struct packed {logic [15:0] x; logic [15:0] y; logic v; logic lt; logic lw;} beat_t;
  typedef struct {int ej, ei, kw, kh, sh, sv, dh, dv, lat, rnd, beats, lx, ly, cycles, frz;} vec_t;

  int    n_cmp = 0, n_err = 0, cyc = 0, n_starts = 0, first_start = -1, first_valid = -1;
  int    lat = 2, cnt;
  logic [15:0] lx_l, ly_l;
  beat_t got[$], exp_q[$], cur, hold;
  logic  pend = 1'b0;
  vec_t  vt[6];

  surface_win_pos_gen #(.SIM_DELAY(1)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .ext_j_right(ext_j_right), .ext_i_bottom(ext_i_bottom),
    .kernel_w(kernel_w), .kernel_h(kernel_h), .stride_h(stride_h), .stride_v(stride_v),
    .dilation_h(dilation_h), .dilation_v(dilation_v),
    .blk_start(blk_start), .blk_idle(blk_idle), .blk_done(blk_done),
    .cvt_start(cvt_start), .cvt_idle(cvt_idle),
    .cvt_i_logic_x(cvt_i_logic_x), .cvt_i_logic_y(cvt_i_logic_y),
    .cvt_done(cvt_done), .cvt_o_phy_x(cvt_o_phy_x), .cvt_o_phy_y(cvt_o_phy_y), .cvt_o_is_vld(cvt_o_is_vld),
    .m_pos_valid(m_pos_valid), .m_pos_ready(m_pos_ready),
    .m_pos_phy_x(m_pos_phy_x), .m_pos_phy_y(m_pos_phy_y), .m_pos_is_vld(m_pos_is_vld),
    .m_pos_last_tap(m_pos_last_tap), .m_pos_last_win(m_pos_last_win)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // converter model: done pulses lat enabled cycles after start, phy = logical + (100,200)
  always @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      cnt <= 0; lx_l <= '0; ly_l <= '0;
    end else if (aclken) begin
      if (cvt_start) begin
        cnt <= lat; lx_l <= cvt_i_logic_x; ly_l <= cvt_i_logic_y;
      end else if (cnt != 0) cnt <= cnt - 1;
    end
  assign cvt_idle     = cnt == 0;
  assign cvt_done     = cnt == 1;
  assign cvt_o_phy_x  = lx_l + 16'd100;
  assign cvt_o_phy_y  = ly_l + 16'd200;
  assign cvt_o_is_vld = lx_l[0];

  // stream monitor: collects beats, checks payload stability and that no start overlaps a pending beat
  always @(negedge aclk) begin
    cur = {m_pos_phy_x, m_pos_phy_y, m_pos_is_vld, m_pos_last_tap, m_pos_last_win};
    if (aresetn) begin
      if (pend && m_pos_valid) begin
        n_cmp++;
        if (cur !== hold) begin
          n_err++;
          $display("FAIL stable_payload: got %h required %h", cur, hold);
        end
      end
      if (aclken && cvt_start) begin
        n_starts++;
        n_cmp++;
        if (m_pos_valid) begin
          n_err++;
          $display("FAIL start_while_out: cvt_start=1 with m_pos_valid=%b required 0", m_pos_valid);
        end
        if (first_start < 0) first_start = cyc;
      end
      if (m_pos_valid && first_valid < 0) first_valid = cyc;
      if (aclken && m_pos_valid && m_pos_ready) got.push_back(cur);
      pend = m_pos_valid && !(aclken && m_pos_ready);
      hold = cur;
    end else pend = 1'b0;
  end

  task automatic chk(input string nm, input longint g, input longint e);
    n_cmp++;
    if (g != e) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, g, e);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic freeze();
    aclken = 1'b0;
    repeat (5) step();
    aclken = 1'b1;
  endtask

  task automatic set_cfg(input vec_t v);
    ext_j_right = 16'(v.ej); ext_i_bottom = 16'(v.ei);
    kernel_w = 4'(v.kw); kernel_h = 4'(v.kh);
    stride_h = 3'(v.sh); stride_v = 3'(v.sv);
    dilation_h = 3'(v.dh); dilation_v = 3'(v.dv);
    lat = v.lat;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_blk_idle"}, blk_idle, 1);
    chk({tag, "_blk_done"}, blk_done, 0);
    chk({tag, "_cvt_start"}, cvt_start, 0);
    chk({tag, "_m_pos_valid"}, m_pos_valid, 0);
    chk({tag, "_logic_x"}, cvt_i_logic_x, 0);
    chk({tag, "_logic_y"}, cvt_i_logic_y, 0);
    chk({tag, "_phy_x"}, m_pos_phy_x, 0);
    chk({tag, "_phy_y"}, m_pos_phy_y, 0);
    chk({tag, "_flags"}, {m_pos_is_vld, m_pos_last_tap, m_pos_last_win}, 0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int t0, td, sh_, sv_, x, y, n;
    bit done, fw, fo;
    v = vt[i];
    set_cfg(v);
    got.delete(); exp_q.delete();
    n_starts = 0; first_start = -1; first_valid = -1;
    step();
    blk_start = 1'b1; t0 = cyc;
    step();
    blk_start = 1'b0;
    done = 0; fw = 0; fo = 0; td = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      if (blk_done) begin
        done = 1; td = cyc;
      end else begin
        if (v.frz != 0 && !fw && !cvt_idle && !m_pos_valid) begin
          fw = 1; freeze();
        end else if (v.frz != 0 && fw && !fo && m_pos_valid) begin
          fo = 1; freeze();
        end
        m_pos_ready = v.rnd != 0 ? ($urandom_range(0, 1) == 1) : 1'b1;
        step();
      end
    end
    m_pos_ready = 1'b1;
    if (!done) chk($sformatf("v%0d_timeout", i), 0, 1);
    step();
    chk($sformatf("v%0d_done_one_cycle", i), blk_done, 0);
    chk($sformatf("v%0d_beats", i), got.size(), v.beats);
    chk($sformatf("v%0d_starts", i), n_starts, v.beats);
    if (v.cycles >= 0) chk($sformatf("v%0d_cycles", i), td - t0, v.cycles);
    if (v.beats > 0 && got.size() > 0) begin
      chk($sformatf("v%0d_first_start", i), first_start - t0, 2);
      if (v.rnd == 0 && v.frz == 0) chk($sformatf("v%0d_first_valid", i), first_valid - t0, 3 + v.lat);
      chk($sformatf("v%0d_last_x", i), got[got.size()-1].x - 16'd100, v.lx);
      chk($sformatf("v%0d_last_y", i), got[got.size()-1].y - 16'd200, v.ly);
    end
    sh_ = v.kw * (v.dh + 1);
    sv_ = v.kh * (v.dv + 1);
    if (sh_ <= v.ej && sv_ <= v.ei)
      for (int by = 0; by + sv_ <= v.ei; by += v.sv + 1)
        for (int bx = 0; bx + sh_ <= v.ej; bx += v.sh + 1)
          for (int ky = 0; ky <= v.kh; ky++)
            for (int kx = 0; kx <= v.kw; kx++) begin
              x = bx + kx * (v.dh + 1);
              y = by + ky * (v.dv + 1);
              exp_q.push_back({16'(x + 100), 16'(y + 200), x[0], kx == v.kw && ky == v.kh, 1'b0});
            end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].lw = 1'b1;
    n = got.size() < exp_q.size() ? got.size() : exp_q.size();
    for (int b = 0; b < n; b++) begin
      n_cmp++;
      if (got[b] !== exp_q[b]) begin
        n_err++;
        $display("FAIL v%0d_beat%0d: got %h required %h", i, b, got[b], exp_q[b]);
      end
    end
  endtask

  initial begin
    vt[0] = '{5, 5, 2, 2, 1, 1, 0, 0, 2, 0, 36, 4, 4, 146, 0};
    vt[1] = '{5, 5, 0, 0, 0, 0, 0, 0, 2, 0, 36, 5, 5, 146, 0};
    vt[2] = '{5, 5, 6, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 2, 0};
    vt[3] = '{5, 5, 2, 2, 1, 1, 0, 0, 3, 1, 36, 4, 4, -1, 0};
    vt[4] = '{7, 7, 1, 1, 2, 2, 1, 1, 1, 0, 16, 5, 5, 50, 0};
    vt[5] = '{5, 5, 2, 2, 1, 1, 0, 0, 2, 0, 36, 4, 4, 156, 1};
    #1;
    check_reset_outputs("por");
    repeat (2) step();
    aresetn = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 6; i++) run_vec(i);
    set_cfg(vt[0]);
    step();
    blk_start = 1'b1;
    step();
    blk_start = 1'b0;
    repeat (20) step();
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    step();
    aresetn = 1'b1;
    step();
    run_vec(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
